// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : stream_mux_pkg                                               |
// | Description : Shared types for the stream_mux_arb slice: the arbitration   |
// |               mode select and the packet-lock state encoding.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : stream_mux_arb_if                                            |
// | Description : Handshake bundle between N producers, the mux and one        |
// |               consumer.                                                    |
// |   mode/sel            arbitration control (fixed select or round-robin)    |
// |   in_valid/in_data    per-channel producer side, in_ready back to them     |
// |   out_valid/out_data  registered consumer side, out_ch = source channel    |
// |   out_ready           consumer back-pressure                               |
// |   in_last/out_last    packet delimiters, only with                         |
// |                       STREAM_MUX_ARB_PKTLOCK_EN defined                    |
// | Modports    : master = producers/consumer (bench), slave = the mux         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface stream_mux_arb_if
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  mode_e                      mode;
  logic [SEL_W-1:0]           sel;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*WIDTH-1:0]  in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_ch;
  logic                       out_ready;
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
  logic [CHANNELS-1:0]        in_last;
  logic                       out_last;
`endif

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
    , output in_last
    , input  out_last
`endif
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
    , input  in_last
    , output out_last
`endif
  );

endinterface
`default_nettype wire

// File: rtl/stream_mux_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational round-robin picker. Returns the first set      |
// |               request at or after ptr+1, wrapping modulo CHANNELS.         |
// |   req      in   CHANNELS  request vector                                   |
// |   ptr      in   SEL_W     last served channel                              |
// |   gnt_idx  out  SEL_W     chosen channel (0 when nothing requested)        |
// |   gnt_vld  out  1         a request was found                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  wire [CHANNELS-1:0] req,
  input  wire [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [SEL_W:0] w_sum;

  // Scan offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_sum   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      w_sum = {1'b0, ptr} + (SEL_W+1)'(i);
      if (w_sum >= (SEL_W+1)'(CHANNELS)) begin
        w_sum = w_sum - (SEL_W+1)'(CHANNELS);
      end
      if (req[w_sum[SEL_W-1:0]]) begin
        gnt_idx = w_sum[SEL_W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_mux_arb                                               |
// | Description : N-channel valid/ready stream mux with fixed-select or        |
// |               round-robin arbitration and a registered output stage that   |
// |               reports the source channel of every beat.                    |
// |   clk    in  rising-edge clock                                             |
// |   rst_n  in  asynchronous active-low reset                                 |
// |   bus    slave modport of stream_mux_arb_if (handshakes, data, control)    |
// | Option      : STREAM_MUX_ARB_PKTLOCK_EN adds in_last/out_last and a lock   |
// |               FSM that keeps a multi-beat packet on one channel.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input wire              clk,
  input wire              rst_n,
  stream_mux_arb_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_ch;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load;
  logic                w_grant;
  logic                w_accept;
  logic                w_rr_vld;
  logic                w_locked;
  logic [SEL_W-1:0]    w_g;
  logic [SEL_W-1:0]    w_rr_idx;
  logic [SEL_W-1:0]    w_lock_ch;
  logic [WIDTH-1:0]    w_ch_data [CHANNELS];

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_unpack
      assign w_ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
    .req     (bus.in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_vld (w_rr_vld)
  );

  // The output register can take a new beat when empty or being drained.
  assign w_load   = !r_out_valid || bus.out_ready;
  assign w_accept = w_load && w_grant;

  // An open packet overrides mode/sel; out-of-range sel (non power-of-two
  // channel counts) simply never grants.
  always_comb begin
    w_g     = '0;
    w_grant = 1'b0;
    if (w_locked) begin
      w_g     = w_lock_ch;
      w_grant = bus.in_valid[w_lock_ch];
    end else if (bus.mode == MODE_RR) begin
      w_g     = w_rr_idx;
      w_grant = w_rr_vld;
    end else if ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS)) begin
      w_g     = bus.sel;
      w_grant = bus.in_valid[bus.sel];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (rst_n && w_accept) begin
      bus.in_ready[w_g] = 1'b1;
    end
  end

  // Data/channel hold their last values when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SEL_W'(CHANNELS-1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_g];
      r_out_ch    <= w_g;
      if (bus.mode == MODE_RR) begin
        r_ptr <= w_g;
      end
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

`ifdef STREAM_MUX_ARB_PKTLOCK_EN
  lock_state_e      r_lock_state;
  lock_state_e      w_lock_state_nx;
  logic [SEL_W-1:0] r_lock_ch;
  logic [SEL_W-1:0] w_lock_ch_nx;
  logic             r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= UNLOCKED;
      r_lock_ch    <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_lock_state <= w_lock_state_nx;
      r_lock_ch    <= w_lock_ch_nx;
      if (w_accept) begin
        r_out_last <= bus.in_last[w_g];
      end
    end
  end

  // A beat without last opens a packet; single-beat packets never lock.
  always_comb begin
    w_lock_state_nx = r_lock_state;
    w_lock_ch_nx    = r_lock_ch;
    case (r_lock_state)
      UNLOCKED: begin
        if (w_accept && !bus.in_last[w_g]) begin
          w_lock_state_nx = LOCKED;
          w_lock_ch_nx    = w_g;
        end
      end
      LOCKED: begin
        if (w_accept && bus.in_last[w_g]) begin
          w_lock_state_nx = UNLOCKED;
        end
      end
      default: w_lock_state_nx = UNLOCKED;
    endcase
  end

  assign w_locked     = (r_lock_state == LOCKED);
  assign w_lock_ch    = r_lock_ch;
  assign bus.out_last = r_out_last;
`else
  assign w_locked  = 1'b0;
  assign w_lock_ch = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stream_mux_arb                                            |
// | Description : Self-checking bench for stream_mux_arb. A reference model    |
// |               predicts in_ready and queues the expected beats; a monitor   |
// |               pops and compares as the consumer takes each beat.           |
// |               Directed scenarios precede a randomized phase. The packet    |
// |               lock scenario is built with STREAM_MUX_ARB_PKTLOCK_EN.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_stream_mux_arb;
  import stream_mux_pkg::*;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = $clog2(CHANNELS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp     = 0;
  int    n_err     = 0;
  int    m_last    = CHANNELS - 1;  // last channel served in round-robin
  bit    m_locked  = 1'b0;
  int    m_lock_ch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ch_data(input int c);
    return bus.in_data[c*WIDTH +: WIDTH];
  endfunction

  // Which channel the rules say should be served now (-1 = none).
  function automatic int model_grant();
    if (m_locked) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
    if (bus.mode == MODE_FIXED) begin
      if (int'(bus.sel) < CHANNELS && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int off = 1; off <= CHANNELS; off++) begin
      if (bus.in_valid[(m_last + off) % CHANNELS]) return (m_last + off) % CHANNELS;
    end
    return -1;
  endfunction

  // Model + monitor, evaluated mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin : monitor
    int                  g;
    logic                ld;
    logic [CHANNELS-1:0] exp_rdy;
    beat_t               b;
    if (!rst_n) begin
      exp_q.delete();
      m_last   = CHANNELS - 1;
      m_locked = 1'b0;
    end else begin
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      ld = (exp_q.size() == 0) || bus.out_ready;
      if (exp_q.size() != 0 && bus.out_ready) begin
        b = exp_q.pop_front();
        check("out_ch", 32'(bus.out_ch), 32'(b.ch));
        check("out_data", 32'(bus.out_data), 32'(b.data));
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
        check("out_last", 32'(bus.out_last), 32'(b.last));
`endif
      end
      g = model_grant();
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (ld && g >= 0) begin
        b.ch   = g;
        b.data = ch_data(g);
        b.last = 1'b0;
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
        b.last = bus.in_last[g];
        if (!m_locked && !b.last) begin
          m_locked  = 1'b1;
          m_lock_ch = g;
        end else if (m_locked && b.last) begin
          m_locked = 1'b0;
        end
`endif
        exp_q.push_back(b);
        if (bus.mode == MODE_RR) m_last = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    bus.in_data = (CHANNELS*WIDTH)'($urandom);
  endtask

  initial begin : stim
    logic [WIDTH-1:0] held;
    bus.mode      = MODE_FIXED;
    bus.sel       = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
    bus.in_last   = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst out_data", 32'(bus.out_data), 0);
    check("rst out_ch", 32'(bus.out_ch), 0);
    check("rst in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b1;

    // Fixed select on channel 2.
    rand_data();
    bus.in_data[2*WIDTH +: WIDTH] = 4'hA;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    #1;
    check("fixed in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check("fixed out_valid", 32'(bus.out_valid), 1);
    check("fixed out_data", 32'(bus.out_data), 32'hA);
    check("fixed out_ch", 32'(bus.out_ch), 2);

    // Round-robin with every channel requesting.
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
      check("rr seq out_ch", 32'(bus.out_ch), 32'(i % 4));
    end

    // Channel 1 beat held under back-pressure, then release.
    bus.in_valid = 4'b0010;
    rand_data();
    step();
    check("hold load ch", 32'(bus.out_ch), 1);
    held          = bus.out_data;
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      check("hold in_ready", 32'(bus.in_ready), 0);
      step();
      check("hold out_ch", 32'(bus.out_ch), 1);
      check("hold out_data", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check("release out_ch", 32'(bus.out_ch), 2);

    // Fixed select on an idle channel: stage empties.
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0001;
    #1;
    check("nogrant in_ready", 32'(bus.in_ready), 0);
    step();
    check("nogrant out_valid", 32'(bus.out_valid), 0);

    // Reset with a beat in the output stage.
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1111;
    rand_data();
    step();
    check("pre-rst out_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 0);
    check("midrst out_data", 32'(bus.out_data), 0);
    check("midrst in_ready", 32'(bus.in_ready), 0);
    step();
    rst_n = 1'b1;
    #1;
    check("postrst in_ready", 32'(bus.in_ready), 32'b0001);
    step();
    check("postrst out_ch", 32'(bus.out_ch), 0);

`ifdef STREAM_MUX_ARB_PKTLOCK_EN
    // Three-beat packet on ch1 must not be interleaved with ch2.
    bus.in_valid = 4'b0110;
    bus.in_last  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      bus.in_last[1] = (i == 2);
      rand_data();
      #1;
      check("pkt in_ready", 32'(bus.in_ready), 32'b0010);
      step();
      check("pkt out_ch", 32'(bus.out_ch), 1);
    end
    bus.in_valid   = 4'b0100;
    bus.in_last[1] = 1'b0;
    #1;
    check("after pkt in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check("after pkt out_ch", 32'(bus.out_ch), 2);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      bus.mode      = ($urandom_range(0, 3) == 0) ? MODE_FIXED : MODE_RR;
      bus.sel       = SEL_W'($urandom_range(0, CHANNELS-1));
      bus.in_valid  = CHANNELS'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_ARB_PKTLOCK_EN
      bus.in_last   = CHANNELS'($urandom);
`endif
      rand_data();
      step();
    end

    // Drain.
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("drain empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel stream multiplexer with valid/ready handshakes, selectable fixed-select or round-robin arbitration, and a registered output stage. It supersedes the purely combinational 4:1 data mux wherever sources are flow-controlled. It sits between multiple producer datapaths and a single consumer and reports which channel each output beat came from.

## Interface
Parameters:
- `WIDTH`, 4, data width per channel (≥1)
- `CHANNELS`, 4, number of input channels (≥2)
- `SEL_W`, `$clog2(CHANNELS)`, localparam, channel-index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  SEL_W  channel index used in fixed mode
- `in_valid`  in  CHANNELS  per-channel valid
- `in_data`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `in_ready`  out  CHANNELS  per-channel ready, one-hot or zero
- `out_valid`  out  1  output beat valid
- `out_data`  out  WIDTH  registered output data
- `out_ch`  out  SEL_W  source channel of the current output beat
- `out_ready`  in  1  consumer ready

## Operation
- Output register is loaded when `load = !out_valid || out_ready`.
- Fixed mode: `g = sel`. A grant exists iff `in_valid[sel]`. No other channel is served.
- Round-robin mode: `g` is the first channel with `in_valid` set, searching from `ptr+1` upward and wrapping modulo CHANNELS. `ptr` updates to `g` only on an accepted beat.
- `in_ready[g] = load && grant`. All other bits are 0.
- A beat transfers on channel k iff `in_valid[k] && in_ready[k]`. `out_data`/`out_ch` load from channel g, and `out_valid` becomes 1.
- If `load` is set and there is no grant, `out_valid` becomes 0. Data and channel hold their last values.
- `out_valid && !out_ready`: `out_data`, `out_ch`, and `out_valid` hold. All `in_ready` bits are 0.
- `mode`/`sel` are sampled every cycle. A change affects only the next grant and never alters a held output beat.
- `ptr` is unchanged in fixed mode.
- CHANNELS not a power of two: a `sel` value ≥ CHANNELS gives no grant.

Reset values (async, `rst_n` low):
- `out_valid` = 0, `out_data` = 0, `out_ch` = 0
- `ptr` = CHANNELS-1, so channel 0 has first priority
- Lock state = UNLOCKED
- `in_ready` forced to 0 while `rst_n` is low.
- Reset mid-stream discards the held beat.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` stays high.
- `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_valid`, `out_ready`, and lock state. `out_*` are registered.
- Simultaneous `out_ready` and a new grant in one cycle: the current beat retires and the new beat loads with no bubble.

## Configuration
- `STREAM_MUX_ARB_PKTLOCK_EN` defined:
  - Adds ports `in_last` (in, CHANNELS) and `out_last` (out, 1, registered, reset 0).
  - Lock FSM, UNLOCKED→LOCKED: on an accepted beat with `in_last[g]=0`, record `lock_ch = g`.
  - In LOCKED, `g = lock_ch` regardless of `mode`/`sel`.
  - LOCKED→UNLOCKED: on an accepted beat with `in_last=1`.
  - A single-beat packet (`last=1`) never locks.
- Not defined: no last ports, no FSM, arbitration per beat.

## Structure
- Package `stream_mux_pkg`: `mode_e` (`MODE_FIXED=1'b0`, `MODE_RR=1'b1`) and `lock_state_e` (`UNLOCKED`, `LOCKED`).
- Sub-module `rr_pick`: combinational rotate + find-first-set, parametrised by CHANNELS. Inputs: request vector and `ptr`. Outputs: grant index and grant-valid.

## Test plan
- Fixed mode, `sel`=2, `in_valid`=4'b0100, `in_data` ch2=4'hA, `out_ready`=1 → `in_ready`=4'b0100. Next cycle `out_valid`=1, `out_data`=A, `out_ch`=2.
- Round-robin, all four valid continuously, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0 on consecutive cycles.
- Round-robin, beat from ch1 held with `out_ready`=0 for 3 cycles → `in_ready`=0, `out_data`/`out_ch` stable. On release, the next grant is ch2.
- Fixed mode, `sel`=3 with only ch0 valid → no grant, `in_ready`=0, `out_valid` drops to 0 after the current beat retires.
- `rst_n` pulsed low with `out_valid`=1 → `out_valid`=0 and `out_data`=0 immediately, `in_ready`=0. After release, first RR grant is ch0.
- With `STREAM_MUX_ARB_PKTLOCK_EN`, RR mode, ch1 sends 3-beat packet (last on beat 3) while ch2 is valid → three ch1 beats back-to-back, then ch2.
